// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
// Defaults assume a 27 MHz system clock.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } deb_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 270_000;     // 10 ms
    localparam int DEF_HOLD_CYCLES     = 27_000_000;  // 1 s

    // Bits needed to count up to the larger of the two cycle limits.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: 2-FF synchronizer, debounce FSM and long-press hold timer.
// All outputs are registered; the press/release pulses coincide with the level change.
module key_debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter bit ACTIVE_LOW_IN   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_held
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    deb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          held_done_q, held_done_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          held_q, held_d;
    logic          down_now, down_next;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        sync1_d     = key_raw ^ ACTIVE_LOW_IN;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        held_done_d = held_done_q;
        held_d      = 1'b0;

        case (state_q)
            RELEASED: begin
                if (sync2_q) begin
                    state_d = PRESS_PEND;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_PEND: begin
                if (!sync2_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASE_PEND;
                    cnt_d   = CW'(1);
                end
            end
            RELEASE_PEND: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_MAX) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase

        down_now  = (state_q == PRESSED) || (state_q == RELEASE_PEND);
        down_next = (state_d == PRESSED) || (state_d == RELEASE_PEND);

        press_d   = (state_q == PRESS_PEND)   && (state_d == PRESSED);
        release_d = (state_q == RELEASE_PEND) && (state_d == RELEASED);
        level_d   = down_next;

        // A bounced release (RELEASE_PEND back to PRESSED) keeps counting.
        if (press_d) begin
            hold_d = '0;
        end else if (down_now && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
        end

        // Never fire on the release edge itself, so key_held cannot trail key_release.
        if (state_d == RELEASED) begin
            held_done_d = 1'b0;
        end else if (down_next && (hold_d == HOLD_MAX) && !held_done_q) begin
            held_d      = 1'b1;
            held_done_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= RELEASED;
            cnt_q       <= '0;
            hold_q      <= '0;
            held_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            held_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            held_done_q <= held_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            held_q      <= held_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_held    = held_q;

endmodule

// File: rtl/key_debouncer.sv
// Debounces WIDTH raw key pins into clean levels plus press/release/long-press pulses.
// Channels are fully independent instances of key_debounce_channel.
module key_debouncer
    import key_debounce_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter bit ACTIVE_LOW_IN   = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release,
    output logic [WIDTH-1:0] key_held
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_debouncer: DEBOUNCE_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("key_debouncer: HOLD_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .ACTIVE_LOW_IN   (ACTIVE_LOW_IN)
        ) u_ch (
            .clock       (clock),
            .reset       (reset),
            .key_raw     (key_raw[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_held    (key_held[i])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer: stimulus queues expected pulses (cycle, kind, channel),
// a negedge monitor pops one entry per observed pulse and compares.
module tb_key_debouncer;

    localparam int W            = 8;
    localparam int KIND_PRESS   = 0;
    localparam int KIND_RELEASE = 1;
    localparam int KIND_HELD    = 2;

    typedef struct {
        int cyc;
        int kind;
        int ch;
    } ev_t;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] key_raw;
    logic [W-1:0] key_level;
    logic [W-1:0] key_press;
    logic [W-1:0] key_release;
    logic [W-1:0] key_held;

    ev_t exp_q[$];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_fails  = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    key_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (16),
        .ACTIVE_LOW_IN   (1'b0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_held    (key_held)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic push(input int c, input int k, input int ch);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.ch   = ch;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: scan kinds in order press, release, held, channels low to high.
    always @(negedge clock) begin
        logic [W-1:0] vec;
        ev_t          e;
        for (int k = 0; k < 3; k++) begin
            case (k)
                KIND_PRESS:   vec = key_press;
                KIND_RELEASE: vec = key_release;
                default:      vec = key_held;
            endcase
            for (int i = 0; i < W; i++) begin
                if (vec[i] !== 1'b0) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("FAIL unexpected pulse: kind %0d on channel %0d at cycle %0d, none expected",
                                 k, i, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("pulse cycle (kind %0d ch %0d)", k, i), cyc, e.cyc);
                        check($sformatf("pulse kind (ch %0d)", i), k, e.kind);
                        check($sformatf("pulse channel (kind %0d)", k), i, e.ch);
                        if (k == KIND_PRESS)
                            check($sformatf("level at press ch %0d", i), key_level[i], 1);
                        else if (k == KIND_RELEASE)
                            check($sformatf("level at release ch %0d", i), key_level[i], 0);
                    end
                end
            end
        end
    end

    initial begin
        int t;

        // 1. Reset: all outputs low even with every key asserted.
        reset   = 1'b0;
        key_raw = '1;
        tick(4);
        check("reset key_level",   key_level,   0);
        check("reset key_press",   key_press,   0);
        check("reset key_release", key_release, 0);
        check("reset key_held",    key_held,    0);
        key_raw = '0;
        reset   = 1'b1;
        tick(10);
        check("post-reset key_level", key_level, 0);
        check("post-reset key_held",  key_held,  0);

        // 2. Clean press/release on key 0: level appears 6 clocks after the first sampling edge.
        t = cyc + 1;
        key_raw[0] = 1'b1;
        push(t + 6, KIND_PRESS, 0);
        tick(15);
        t = cyc + 1;
        key_raw[0] = 1'b0;
        push(t + 6, KIND_RELEASE, 0);
        tick(12);

        // 3. Bounce on key 1: 2-cycle pulses are rejected, one press after settling.
        key_raw[1] = 1'b1; tick(2);
        key_raw[1] = 1'b0; tick(2);
        key_raw[1] = 1'b1; tick(2);
        key_raw[1] = 1'b0; tick(2);
        t = cyc + 1;
        key_raw[1] = 1'b1;
        push(t + 6, KIND_PRESS, 1);
        tick(12);
        t = cyc + 1;
        key_raw[1] = 1'b0;
        push(t + 6, KIND_RELEASE, 1);
        tick(12);

        // 4. Long press on key 2: held 16 cycles after press, then again on a re-press.
        t = cyc + 1;
        key_raw[2] = 1'b1;
        push(t + 6,  KIND_PRESS, 2);
        push(t + 22, KIND_HELD,  2);
        tick(36);
        t = cyc + 1;
        key_raw[2] = 1'b0;
        push(t + 6, KIND_RELEASE, 2);
        tick(12);
        t = cyc + 1;
        key_raw[2] = 1'b1;
        push(t + 6,  KIND_PRESS, 2);
        push(t + 22, KIND_HELD,  2);
        tick(13);
        key_raw[2] = 1'b0;   // short release glitch must not restart the hold count
        tick(2);
        key_raw[2] = 1'b1;
        tick(14);
        check("level through glitch ch 2", key_level[2], 1);
        t = cyc + 1;
        key_raw[2] = 1'b0;
        push(t + 6, KIND_RELEASE, 2);
        tick(12);

        // 5. Key 3 short press alongside key 4 long press.
        t = cyc + 1;
        key_raw[3] = 1'b1;
        key_raw[4] = 1'b1;
        push(t + 6,  KIND_PRESS,   3);
        push(t + 6,  KIND_PRESS,   4);
        push(t + 18, KIND_RELEASE, 3);
        push(t + 22, KIND_HELD,    4);
        tick(12);
        key_raw[3] = 1'b0;
        tick(20);
        t = cyc + 1;
        key_raw[4] = 1'b0;
        push(t + 6, KIND_RELEASE, 4);
        tick(12);

        // 6. Reset while key 5 is mid-debounce (cnt=2): needs a full fresh debounce afterwards.
        t = cyc + 1;
        key_raw[5] = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(1);
        check("mid-reset key_level", key_level, 0);
        check("mid-reset key_press", key_press, 0);
        tick(2);
        t = cyc + 1;
        reset = 1'b1;
        push(t + 6, KIND_PRESS, 5);
        tick(12);
        t = cyc + 1;
        key_raw[5] = 1'b0;
        push(t + 6, KIND_RELEASE, 5);
        tick(12);

        check("final key_level", key_level, 0);
        check("pending expected pulses", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
